// File: rtl/hazard_pkg.sv
// hazard_pkg -- shared widths and Tuse/Tnew encodings for the decode-stage
// hazard scoreboard.
//   TW     : width of every Tuse / Tnew / latency field
//   XLAT_W : width of the multi-cycle unit (XALU) occupancy field
//   REG_W  : architectural register-id width
package hazard_pkg;

  localparam int TW     = 3;
  localparam int XLAT_W = 6;
  localparam int REG_W  = 5;

  // Named pipeline distances used for Tuse (when an operand is consumed) and
  // Tnew (when a result becomes forwardable), counted from decode.
  typedef enum logic [2:0] {
    T_NOW            = 3'd0,
    T_EX             = 3'd1,
    T_MEM            = 3'd2,
    T_WB             = 3'd3,
    T_UNALIGNED_LOAD = 3'd4
  } tdist_e;

  // A register id is tracked when it is nonzero and inside the register file.
  function automatic logic is_tracked(input logic [REG_W-1:0] r, input int nregs);
    return (r != '0) && (int'(r) < nregs);
  endfunction

endpackage

// File: rtl/sat_down_cnt.sv
// sat_down_cnt -- loadable down counter that saturates at zero.
//   clk, resetn : clock, asynchronous active-low reset (clears the count)
//   load        : load load_val this cycle (wins over dec_en)
//   load_val    : value to load
//   dec_en      : decrement by one when the count is nonzero
//   clr         : synchronous clear, highest priority
//   cnt         : current count
module sat_down_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec_en,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (dec_en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard -- decode-stage RAW / XALU / serialize hazard detection.
// Each GPR (1..NUM_REGS-1) has a remaining-Tnew counter; a source stalls
// decode while its producer's counter exceeds the source's Tuse. The XALU
// has its own occupancy counter that runs down every cycle.
//   clk, resetn                 : clock, asynchronous active-low reset
//   adv_i, flush_i              : pipeline advance, exception flush
//   issue_valid_i               : decoded instruction present
//   src_valid_i/reg_i/tuse_i    : per-source need, register id, Tuse
//   dst_valid_i/reg_i/tnew_i    : destination write, register id, Tnew
//   xalu_use_i, xalu_lat_i      : XALU needed, occupancy it starts
//   serialize_i                 : wait until no result is outstanding
//   stall_o, issue_ok_o         : hold decode, instruction accepted
//   xalu_busy_o, pending_o      : XALU occupied, any register outstanding
module hazard_scoreboard #(
  parameter int NUM_SRC  = 2,
  parameter int NUM_REGS = 32,
  parameter int TW       = hazard_pkg::TW,
  parameter int XLAT_W   = hazard_pkg::XLAT_W
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic                               adv_i,
  input  logic                               flush_i,
  input  logic                               issue_valid_i,
  input  logic [NUM_SRC-1:0]                 src_valid_i,
  input  logic [NUM_SRC*hazard_pkg::REG_W-1:0] src_reg_i,
  input  logic [NUM_SRC*TW-1:0]              src_tuse_i,
  input  logic                               dst_valid_i,
  input  logic [hazard_pkg::REG_W-1:0]       dst_reg_i,
  input  logic [TW-1:0]                      dst_tnew_i,
  input  logic                               xalu_use_i,
  input  logic [XLAT_W-1:0]                  xalu_lat_i,
  input  logic                               serialize_i,
  output logic                               stall_o,
  output logic                               issue_ok_o,
  output logic                               xalu_busy_o,
  output logic                               pending_o
);

  import hazard_pkg::*;

  logic [NUM_REGS-1:0][TW-1:0] reg_cnt;
  logic [NUM_REGS-1:0]         pend_vec;
  logic [NUM_SRC-1:0]          raw_vec;
  logic [XLAT_W-1:0]           xalu_cnt;
  logic                        xalu_haz;
  logic                        ser_haz;

  // Register 0 is hard-wired: no counter, never pending.
  assign reg_cnt[0]  = '0;
  assign pend_vec[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
      logic load_reg;
      // issue_ok_o already excludes flush, so a flush can never also load.
      assign load_reg = issue_ok_o & dst_valid_i & (dst_reg_i == REG_W'(gi));

      sat_down_cnt #(.W(TW)) u_cnt (
        .clk      (clk),
        .resetn   (resetn),
        .load     (load_reg),
        .load_val (dst_tnew_i),
        .dec_en   (adv_i),
        .clr      (flush_i),
        .cnt      (reg_cnt[gi])
      );

      assign pend_vec[gi] = |reg_cnt[gi];
    end

    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [REG_W-1:0] sreg;
      logic [TW-1:0]    stuse;
      logic [TW-1:0]    scnt;

      assign sreg  = src_reg_i[gi*REG_W +: REG_W];
      assign stuse = src_tuse_i[gi*TW +: TW];

      // Look up the pre-update counter; ids outside the file read as zero.
      always_comb begin
        scnt = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
          if (sreg == REG_W'(r)) begin
            scnt = reg_cnt[r];
          end
        end
      end

      assign raw_vec[gi] = src_valid_i[gi] & is_tracked(sreg, NUM_REGS) & (scnt > stuse);
    end
  endgenerate

  // The XALU runs to completion regardless of pipeline advance or flush.
  sat_down_cnt #(.W(XLAT_W)) u_xalu_cnt (
    .clk      (clk),
    .resetn   (resetn),
    .load     (issue_ok_o & xalu_use_i),
    .load_val (xalu_lat_i),
    .dec_en   (1'b1),
    .clr      (1'b0),
    .cnt      (xalu_cnt)
  );

  assign xalu_busy_o = |xalu_cnt;
  assign pending_o   = |pend_vec;
  assign xalu_haz    = xalu_use_i & xalu_busy_o;
  assign ser_haz     = serialize_i & pending_o;

  assign stall_o    = issue_valid_i & ~flush_i & ((|raw_vec) | xalu_haz | ser_haz);
  assign issue_ok_o = issue_valid_i & adv_i & ~stall_o & ~flush_i;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        resetn;
  logic        adv, fl, iv, dv, xu, ser;
  logic [1:0]  sv;
  logic [9:0]  sreg;
  logic [5:0]  stuse;
  logic [4:0]  dr;
  logic [2:0]  tn;
  logic [5:0]  xl;
  logic        stall_o, issue_ok_o, xalu_busy_o, pending_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: remaining Tnew per register, XALU remaining occupancy.
  int m_cnt[32];
  int m_x;

  always #5 clk = ~clk;

  hazard_scoreboard #(.NUM_SRC(2), .NUM_REGS(32), .TW(3), .XLAT_W(6)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .adv_i         (adv),
    .flush_i       (fl),
    .issue_valid_i (iv),
    .src_valid_i   (sv),
    .src_reg_i     (sreg),
    .src_tuse_i    (stuse),
    .dst_valid_i   (dv),
    .dst_reg_i     (dr),
    .dst_tnew_i    (tn),
    .xalu_use_i    (xu),
    .xalu_lat_i    (xl),
    .serialize_i   (ser),
    .stall_o       (stall_o),
    .issue_ok_o    (issue_ok_o),
    .xalu_busy_o   (xalu_busy_o),
    .pending_o     (pending_o)
  );

  function automatic bit m_pending();
    for (int r = 1; r < 32; r++) if (m_cnt[r] != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_stall();
    bit h = 1'b0;
    for (int i = 0; i < 2; i++) begin
      int r, t;
      r = int'((sreg >> (5 * i)) & 10'd31);
      t = int'((stuse >> (3 * i)) & 6'd7);
      if (sv[i] && r != 0 && m_cnt[r] > t) h = 1'b1;
    end
    if (xu && m_x != 0) h = 1'b1;
    if (ser && m_pending()) h = 1'b1;
    return iv && !fl && h;
  endfunction

  function automatic bit m_ok();
    return iv && adv && !fl && !m_stall();
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < 32; r++) m_cnt[r] <= 0;
      m_x <= 0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (fl) m_cnt[r] <= 0;
        else if (m_ok() && dv && int'(dr) == r) m_cnt[r] <= int'(tn);
        else if (adv && m_cnt[r] > 0) m_cnt[r] <= m_cnt[r] - 1;
      end
      if (m_ok() && xu) m_x <= int'(xl);
      else if (m_x > 0) m_x <= m_x - 1;
    end
  end

  task automatic cmp(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic lit(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end else begin
      $display("check %s: %0d at %0t", name, got, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    cmp("stall_o", stall_o, m_stall());
    cmp("issue_ok_o", issue_ok_o, m_ok());
    cmp("xalu_busy_o", xalu_busy_o, m_x != 0);
    cmp("pending_o", pending_o, m_pending());
  end

  task automatic idle();
    iv = 0; adv = 1; fl = 0; sv = '0; sreg = '0; stuse = '0;
    dv = 0; dr = '0; tn = '0; xu = 0; xl = '0; ser = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    resetn = 1'b0;
    idle();
    // Reset: nothing tracked, accepted whenever valid and advancing.
    iv = 1; dv = 1; dr = 5'd4; tn = 3'd3;
    #2;
    lit("reset_stall", int'(stall_o), 0);
    lit("reset_issue_ok", int'(issue_ok_o), 1);
    lit("reset_busy", int'(xalu_busy_o), 0);
    tick();
    lit("reset_pending_held", int'(pending_o), 0);
    resetn = 1'b1;
    idle();
    tick();

    // Load-use: lw r5 Tnew=3 then addu reading r5 with Tuse=1.
    iv = 1; dv = 1; dr = 5'd5; tn = 3'd3;
    #1 lit("lw_issue", int'(issue_ok_o), 1);
    tick();
    idle();
    iv = 1; sv = 2'b01; sreg = 10'd5; stuse = 6'd1; dv = 1; dr = 5'd6; tn = 3'd1;
    #1 lit("loaduse_stall0", int'(stall_o), 1);
    n = 0;
    while (stall_o && n < 8) begin tick(); n++; end
    lit("loaduse_stall_cycles", n, 2);
    lit("loaduse_issue", int'(issue_ok_o), 1);
    tick();

    // Forwarding: addu r3 Tnew=2 then sw reading r3 (source 1) with Tuse=2.
    idle();
    iv = 1; dv = 1; dr = 5'd3; tn = 3'd2;
    tick();
    idle();
    iv = 1; sv = 2'b10; sreg = {5'd3, 5'd0}; stuse = {3'd1, 3'd0};
    #1 lit("fwd_tuse1_stall", int'(stall_o), 1);
    stuse = {3'd2, 3'd0};
    #1 lit("fwd_tuse2_stall", int'(stall_o), 0);
    lit("fwd_issue", int'(issue_ok_o), 1);
    tick();

    // XALU: div lat 32, one bubble, then mfhi with adv low throughout.
    idle();
    iv = 1; xu = 1; xl = 6'd32;
    #1 lit("div_issue", int'(issue_ok_o), 1);
    tick();
    idle();
    tick();
    iv = 1; xu = 1; adv = 0; dv = 1; dr = 5'd2; tn = 3'd1;
    #1 lit("mfhi_busy", int'(xalu_busy_o), 1);
    n = 0;
    while (stall_o && n < 40) begin tick(); n++; end
    lit("xalu_stall_cycles", n, 31);
    adv = 1;
    #1 lit("mfhi_issue", int'(issue_ok_o), 1);
    tick();
    idle();
    repeat (4) tick();

    // Serialize: r7 counter 2, then a serializing instruction.
    iv = 1; dv = 1; dr = 5'd7; tn = 3'd2;
    tick();
    idle();
    #1 lit("ser_pending", int'(pending_o), 1);
    iv = 1; ser = 1;
    #1;
    n = 0;
    while (stall_o && n < 10) begin tick(); n++; end
    lit("ser_stall_cycles", n, 2);
    lit("ser_issue", int'(issue_ok_o), 1);
    tick();

    // Flush: r9 counter 3 plus an XALU op, then one flush cycle.
    idle();
    iv = 1; dv = 1; dr = 5'd9; tn = 3'd3; xu = 1; xl = 6'd5;
    tick();
    idle();
    iv = 1; fl = 1; sv = 2'b01; sreg = 10'd9; stuse = 6'd0;
    #1 lit("flush_stall", int'(stall_o), 0);
    lit("flush_issue", int'(issue_ok_o), 0);
    tick();
    idle();
    #1 lit("flush_pending", int'(pending_o), 0);
    lit("flush_xalu_kept", int'(xalu_busy_o), 1);
    iv = 1; sv = 2'b01; sreg = 10'd9; stuse = 6'd0;
    #1 lit("flush_reader_stall", int'(stall_o), 0);
    lit("flush_reader_issue", int'(issue_ok_o), 1);
    tick();

    // Register 0 is never tracked.
    idle();
    iv = 1; dv = 1; dr = 5'd0; tn = 3'd4;
    tick();
    idle();
    #1 lit("r0_pending", int'(pending_o), 0);
    iv = 1; sv = 2'b01; sreg = 10'd0; stuse = 6'd0;
    #1 lit("r0_reader_stall", int'(stall_o), 0);
    tick();

    // Mid-operation reset abandons outstanding hazards at once.
    idle();
    iv = 1; dv = 1; dr = 5'd4; tn = 3'd3;
    tick();
    idle();
    iv = 1; sv = 2'b01; sreg = 10'd4; stuse = 6'd0;
    #1 lit("r4_stall", int'(stall_o), 1);
    resetn = 1'b0;
    #1 lit("rst_pending", int'(pending_o), 0);
    lit("rst_stall", int'(stall_o), 0);
    lit("rst_issue_ok", int'(issue_ok_o), 1);
    tick();
    resetn = 1'b1;
    idle();
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2, meaning source operands checked per issuing instruction.
REQ-002 SHALL have parameter NUM_REGS, default 32, meaning architectural GPRs tracked; register 0 is never tracked.
REQ-003 SHALL have parameter TW, default 3, meaning width of every Tuse, Tnew and latency field.
REQ-004 SHALL have parameter XLAT_W, default 6, meaning width of the multi-cycle unit (XALU) latency field.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 SHALL have clk, input, 1, meaning the clock.
REQ-007 SHALL have resetn, input, 1, meaning the asynchronous active-low reset.
REQ-008 SHALL have adv_i, input, 1, meaning the pipeline advances this cycle.
REQ-009 SHALL have flush_i, input, 1, meaning exception flush.
REQ-010 SHALL have issue_valid_i, input, 1, meaning a decoded instruction is present.
REQ-011 SHALL have src_valid_i, input, NUM_SRC, meaning each source is needed.
REQ-012 SHALL have src_reg_i, input, NUM_SRC*5, meaning the source register ids.
REQ-013 SHALL have src_tuse_i, input, NUM_SRC*TW, meaning cycles until each source is consumed.
REQ-014 SHALL have dst_valid_i, input, 1, meaning the instruction writes a GPR.
REQ-015 SHALL have dst_reg_i, input, 5, meaning the destination register id.
REQ-016 SHALL have dst_tnew_i, input, TW, meaning cycles until the result becomes forwardable.
REQ-017 SHALL have xalu_use_i, input, 1, meaning the instruction needs the XALU (mult/div/HI/LO family).
REQ-018 SHALL have xalu_lat_i, input, XLAT_W, meaning the XALU occupancy this instruction starts (0 means the XALU is used without being occupied).
REQ-019 SHALL have serialize_i, input, 1, meaning the instruction must wait until every tracked result is ready.
REQ-020 SHALL have stall_o, output, 1, meaning hold decode.
REQ-021 SHALL have issue_ok_o, output, 1, meaning the instruction is accepted this cycle.
REQ-022 SHALL have xalu_busy_o, output, 1, meaning the XALU counter is nonzero.
REQ-023 SHALL have pending_o, output, 1, meaning at least one register counter is nonzero.

Function
REQ-024 SHALL keep one TW-bit remaining-Tnew counter for each of registers 1..NUM_REGS-1.
REQ-025 SHALL detect a RAW hazard on source i when src_valid_i[i] is set, the source register is nonzero, and its counter is greater than src_tuse_i[i].
REQ-026 SHALL detect an XALU hazard when xalu_use_i is set and the XALU counter is nonzero.
REQ-027 SHALL detect a serialize hazard when serialize_i is set and pending_o is set.
REQ-028 SHALL drive stall_o = issue_valid_i & !flush_i & (any RAW hazard | XALU hazard | serialize hazard), combinationally, with zero-cycle latency.
REQ-029 SHALL drive issue_ok_o = issue_valid_i & adv_i & !stall_o & !flush_i.
REQ-030 SHALL, on an adv_i cycle, decrement every nonzero register counter by 1, saturating at 0.
REQ-031 SHALL hold every register counter unchanged when adv_i is low.
REQ-032 SHALL, when issue_ok_o is set and dst_valid_i is set with dst_reg_i nonzero, load counter[dst_reg_i] with dst_tnew_i; the load overrides the same-cycle decrement.
REQ-033 SHALL never write counter 0, and SHALL ignore dst_valid_i when dst_reg_i is 0.
REQ-034 SHALL decrement the XALU counter every cycle while it is nonzero, independent of adv_i.
REQ-035 SHALL load the XALU counter with xalu_lat_i on issue_ok_o & xalu_use_i; the load overrides the decrement.
REQ-036 SHALL, on flush_i, clear all register counters on the next edge, with flush taking priority over load and decrement.
REQ-037 SHALL NOT clear the XALU counter on flush_i, because the XALU runs to completion.
REQ-038 SHALL compare a source against the counter value from before the current-cycle update (no same-cycle self-bypass).

Reset
REQ-039 SHALL, while resetn is low, hold all register counters and the XALU counter at 0, so that stall_o=0, issue_ok_o=issue_valid_i&adv_i, xalu_busy_o=0 and pending_o=0.
REQ-040 SHALL, when reset asserts mid-operation, abandon all pending hazards immediately.

Structure
REQ-041 SHALL place TW, XLAT_W, the register-id width (5) and the named Tuse/Tnew encodings (T_NOW=0, T_EX=1, T_MEM=2, T_WB=3, T_UNALIGNED_LOAD=4) in the shared package hazard_pkg.
REQ-042 SHALL implement each register counter, and the XALU counter, as an instance of the sub-module sat_down_cnt (load, dec_en, clr, cnt).

Verification
REQ-043 SHALL verify the load-use case: issue lw to r5 with Tnew=3, then addu reading r5 with Tuse=1 -> stall_o=1 for 2 advancing cycles, then issue_ok_o=1.
REQ-044 SHALL verify forwarding: addu writes r3 with Tnew=2, then sw reads r3 with Tuse=2 -> no stall.
REQ-045 SHALL verify the XALU: div with xalu_lat=32, then mfhi -> stall for 31 cycles, even with adv_i low for the whole time.
REQ-046 SHALL verify serialize: counters hold r7=2; issue an instruction with serialize_i=1 -> stall for 2 advancing cycles.
REQ-047 SHALL verify flush: r9 counter=3, then flush_i for one cycle -> pending_o=0 next cycle, and a reader of r9 issues without stall.
REQ-048 SHALL verify register 0 and reset: dst_reg=0 with Tnew=4 -> pending_o stays 0; asserting resetn low with r4=3 -> counter 0 immediately.
